// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a shared single-cycle integer ALU.
// Each operation runs IDLE -> EXEC -> RESP. The result is held until the owning
// requester accepts it.
// Optional build macro ALU_ARB_ROUND_ROBIN_EN selects round-robin grant.
// When it is undefined, requester 0 has fixed priority.
module alu_arbiter #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            req_valid,
   output logic [1:0]            req_ready,
   input  logic [5:0]            req0_op,
   input  logic [DATA_WIDTH-1:0] req0_a,
   input  logic [DATA_WIDTH-1:0] req0_b,
   input  logic [5:0]            req1_op,
   input  logic [DATA_WIDTH-1:0] req1_a,
   input  logic [DATA_WIDTH-1:0] req1_b,
   output logic [1:0]            resp_valid,
   input  logic [1:0]            resp_ready,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic                  alu_e,
   output logic [5:0]            alu_op,
   output logic [DATA_WIDTH-1:0] alu_a,
   output logic [DATA_WIDTH-1:0] alu_b,
   input  logic [DATA_WIDTH-1:0] alu_out,
   output logic                  busy
);

   localparam int unsigned OP_W = 6;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_RESP
   } state_t;

   state_t                state_q, state_d;
   logic                  owner_q, owner_d;
   logic [1:0]            resp_valid_q, resp_valid_d;
   logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
   logic                  alu_e_q, alu_e_d;
   logic [OP_W-1:0]       alu_op_q, alu_op_d;
   logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
   logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
   logic                  busy_q, busy_d;
   logic                  grant_c;
   logic                  accept_c;

`ifdef ALU_ARB_ROUND_ROBIN_EN
   logic last_grant_q, last_grant_d;
`endif

   // Grant selection: a lone requester wins. On contention, policy depends on the build.
   always_comb begin
      grant_c = 1'b0;
      if (req_valid == 2'b10) begin
         grant_c = 1'b1;
      end else if (req_valid == 2'b11) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
         grant_c = ~last_grant_q;
`else
         grant_c = 1'b0;
`endif
      end
   end

   // Ready is offered only in IDLE and only to the granted requester. It is held low while in reset.
   always_comb begin
      req_ready = 2'b00;
      if (rst_n && (state_q == ST_IDLE) && (req_valid != 2'b00)) begin
         req_ready = grant_c ? 2'b10 : 2'b01;
      end
   end

   assign accept_c = |(req_valid & req_ready);

   // Next-state and registered-output values
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      resp_valid_d = resp_valid_q;
      resp_data_d  = resp_data_q;
      alu_e_d      = 1'b0;
      alu_op_d     = alu_op_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      busy_d       = busy_q;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      last_grant_d = last_grant_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               state_d  = ST_EXEC;
               owner_d  = grant_c;
               alu_op_d = grant_c ? req1_op : req0_op;
               alu_a_d  = grant_c ? req1_a  : req0_a;
               alu_b_d  = grant_c ? req1_b  : req0_b;
               alu_e_d  = 1'b1;
               busy_d   = 1'b1;
`ifdef ALU_ARB_ROUND_ROBIN_EN
               last_grant_d = grant_c;
`endif
            end
         end
         ST_EXEC: begin
            state_d      = ST_RESP;
            resp_data_d  = alu_out;
            resp_valid_d = owner_q ? 2'b10 : 2'b01;
         end
         ST_RESP: begin
            if (resp_ready[owner_q]) begin
               state_d      = ST_IDLE;
               resp_valid_d = 2'b00;
               busy_d       = 1'b0;
            end
         end
         default: begin
            state_d      = ST_IDLE;
            resp_valid_d = 2'b00;
            busy_d       = 1'b0;
         end
      endcase
   end

   // State and output registers. Reset discards any in-flight operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         owner_q      <= 1'b0;
         resp_valid_q <= 2'b00;
         resp_data_q  <= '0;
         alu_e_q      <= 1'b0;
         alu_op_q     <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         busy_q       <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
         last_grant_q <= 1'b1;
`endif
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         alu_e_q      <= alu_e_d;
         alu_op_q     <= alu_op_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         busy_q       <= busy_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign alu_e      = alu_e_q;
   assign alu_op     = alu_op_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter, with a behavioural ALU stub and a transaction-level reference model.
// Covers both grant policies, selected by ALU_ARB_ROUND_ROBIN_EN.
module tb_alu_arbiter;

   localparam int unsigned DW = 32;

   localparam logic [5:0] ALU_OP_PLUS            = 6'h00;
   localparam logic [5:0] ALU_OP_SUB             = 6'h01;
   localparam logic [5:0] ALU_OP_AND             = 6'h02;
   localparam logic [5:0] ALU_OP_OR              = 6'h03;
   localparam logic [5:0] ALU_OP_XOR             = 6'h04;
   localparam logic [5:0] ALU_OP_SET_LESS_THAN   = 6'h05;
   localparam logic [5:0] ALU_OP_SET_LESS_THAN_U = 6'h06;
   localparam logic [5:0] ALU_OP_SLL             = 6'h07;
   localparam logic [5:0] ALU_OP_SRL             = 6'h08;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [1:0]    req_valid = 2'b00;
   logic [1:0]    req_ready;
   logic [5:0]    req0_op = '0, req1_op = '0;
   logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [1:0]    resp_valid;
   logic [1:0]    resp_ready = 2'b00;
   logic [DW-1:0] resp_data;
   logic          alu_e;
   logic [5:0]    alu_op;
   logic [DW-1:0] alu_a, alu_b;
   logic [DW-1:0] alu_out;
   logic          busy;

   int n_checks = 0;
   int n_errors = 0;
   int last_g = 1;

   alu_arbiter #(.DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .alu_e(alu_e), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_out(alu_out), .busy(busy)
   );

   always #5 clk = ~clk;

   // Behavioural shared ALU. Undefined opcodes produce zero.
   function automatic logic [DW-1:0] alu_fn(input logic [5:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
      case (op)
         ALU_OP_PLUS:            return a + b;
         ALU_OP_SUB:             return a - b;
         ALU_OP_AND:             return a & b;
         ALU_OP_OR:              return a | b;
         ALU_OP_XOR:             return a ^ b;
         ALU_OP_SET_LESS_THAN:   return ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
         ALU_OP_SET_LESS_THAN_U: return (a < b) ? DW'(1) : DW'(0);
         ALU_OP_SLL:             return a << b[4:0];
         ALU_OP_SRL:             return a >> b[4:0];
         default:                return '0;
      endcase
   endfunction

   always_comb alu_out = alu_fn(alu_op, alu_a, alu_b);

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Model of the grant policy.
   function automatic int model_grant(input logic [1:0] v);
      if (v == 2'b01) return 0;
      if (v == 2'b10) return 1;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      return (last_g == 1) ? 0 : 1;
`else
      return 0;
`endif
   endfunction

   function automatic logic [1:0] onehot(input int g);
      return (g == 1) ? 2'b10 : 2'b01;
   endfunction

   // One complete transaction with checks at every stage. It is entered and left at posedge+1ish.
   task automatic do_txn(input logic [1:0] vld,
                         input logic [5:0] op0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                         input logic [5:0] op1, input logic [DW-1:0] a1, input logic [DW-1:0] b1,
                         input int hold, output int g_got, output logic [DW-1:0] d_got);
      int g;
      logic [5:0] op;
      logic [DW-1:0] a, b, exp;
      req_valid = vld; req0_op = op0; req0_a = a0; req0_b = b0;
      req1_op = op1; req1_a = a1; req1_b = b1; resp_ready = 2'b00;
      #1;
      g = model_grant(vld);
      check("idle_req_ready", 64'(req_ready), 64'(onehot(g)));
      check("idle_busy", 64'(busy), 64'(0));
      g_got = req_ready[1] ? 1 : 0;
      op = (g == 1) ? op1 : op0;
      a  = (g == 1) ? a1 : a0;
      b  = (g == 1) ? b1 : b0;
      exp = alu_fn(op, a, b);
      last_g = g;
      @(posedge clk); #1;
      // Scramble the request side. The captured payload must not follow it.
      req_valid = 2'($urandom); req0_op = 6'($urandom); req1_op = 6'($urandom);
      req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
      #1;
      check("exec_req_ready", 64'(req_ready), 64'(0));
      check("exec_alu_e", 64'(alu_e), 64'(1));
      check("exec_alu_op", 64'(alu_op), 64'(op));
      check("exec_alu_a", 64'(alu_a), 64'(a));
      check("exec_alu_b", 64'(alu_b), 64'(b));
      check("exec_busy", 64'(busy), 64'(1));
      check("exec_resp_valid", 64'(resp_valid), 64'(0));
      @(posedge clk); #1;
      check("resp_valid", 64'(resp_valid), 64'(onehot(g)));
      check("resp_data", 64'(resp_data), 64'(exp));
      check("resp_alu_e", 64'(alu_e), 64'(0));
      check("resp_alu_op_hold", 64'(alu_op), 64'(op));
      check("resp_req_ready", 64'(req_ready), 64'(0));
      d_got = resp_data;
      for (int i = 0; i < hold; i++) begin
         resp_ready = ($urandom_range(0, 1) == 1) ? ~onehot(g) : 2'b00;
         @(posedge clk); #1;
         check("hold_resp_valid", 64'(resp_valid), 64'(onehot(g)));
         check("hold_resp_data", 64'(resp_data), 64'(exp));
         check("hold_req_ready", 64'(req_ready), 64'(0));
         check("hold_busy", 64'(busy), 64'(1));
      end
      resp_ready = onehot(g) | (($urandom_range(0, 1) == 1) ? ~onehot(g) : 2'b00);
      @(posedge clk); #1;
      resp_ready = 2'b00; req_valid = 2'b00;
      #1;
      check("done_resp_valid", 64'(resp_valid), 64'(0));
      check("done_busy", 64'(busy), 64'(0));
      check("done_alu_e", 64'(alu_e), 64'(0));
   endtask

   int g_seq [4];
   int g_tmp;
   logic [DW-1:0] d_tmp;
   logic [DW-1:0] d_seq [4];

   initial begin
      // Reset state. A valid request must not see ready while in reset.
      req_valid = 2'b01;
      #3;
      check("rst_req_ready", 64'(req_ready), 64'(0));
      check("rst_resp_valid", 64'(resp_valid), 64'(0));
      check("rst_resp_data", 64'(resp_data), 64'(0));
      check("rst_alu_e", 64'(alu_e), 64'(0));
      check("rst_alu_op", 64'(alu_op), 64'(0));
      check("rst_alu_a", 64'(alu_a), 64'(0));
      check("rst_alu_b", 64'(alu_b), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      req_valid = 2'b00;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single requester 0: 5 + 7
      do_txn(2'b01, ALU_OP_PLUS, 32'd5, 32'd7, '0, '0, '0, 0, g_tmp, d_tmp);
      check("plus_grant", 64'(g_tmp), 64'(0));
      check("plus_data", 64'(d_tmp), 64'd12);

      // Response held for four cycles
      do_txn(2'b10, ALU_OP_OR, 32'h0F00, 32'h00F0, ALU_OP_OR, 32'h1200, 32'h0034, 4, g_tmp, d_tmp);
      check("hold_data", 64'(d_tmp), 64'h1234);

      // Signed and unsigned set-less-than
      do_txn(2'b01, ALU_OP_SET_LESS_THAN, 32'hFFFF_FFFF, 32'd1, '0, '0, '0, 0, g_tmp, d_tmp);
      check("slt_data", 64'(d_tmp), 64'd1);
      do_txn(2'b01, ALU_OP_SET_LESS_THAN_U, 32'hFFFF_FFFF, 32'd1, '0, '0, '0, 0, g_tmp, d_tmp);
      check("sltu_data", 64'(d_tmp), 64'd0);

      // Undefined opcode passes through and yields the ALU's zero
      do_txn(2'b10, '0, '0, '0, 6'h3F, 32'hDEAD, 32'hBEEF, 1, g_tmp, d_tmp);
      check("undef_data", 64'(d_tmp), 64'd0);

      // Contention: both requesters valid throughout
      last_g = 1;
      rst_n = 1'b0; #1; rst_n = 1'b1;
      for (int i = 0; i < 4; i++)
         do_txn(2'b11, ALU_OP_SUB, 32'd10, 32'd3, ALU_OP_XOR, 32'hF0, 32'hFF, 0,
                g_seq[i], d_seq[i]);
`ifdef ALU_ARB_ROUND_ROBIN_EN
      for (int i = 0; i < 4; i++) begin
         check("rr_grant", 64'(g_seq[i]), 64'(i % 2));
         check("rr_data", 64'(d_seq[i]), (i % 2 == 0) ? 64'd7 : 64'h0F);
      end
`else
      for (int i = 0; i < 4; i++) begin
         check("fixed_grant", 64'(g_seq[i]), 64'd0);
         check("fixed_data", 64'(d_seq[i]), 64'd7);
      end
`endif

      // Reset during EXEC discards the operation
      req_valid = 2'b01; req0_op = ALU_OP_AND; req0_a = 32'hFF; req0_b = 32'h0F;
      @(posedge clk); #1;
      req_valid = 2'b00;
      check("pre_rst_alu_e", 64'(alu_e), 64'(1));
      rst_n = 1'b0; last_g = 1;
      #1;
      check("mid_rst_alu_e", 64'(alu_e), 64'(0));
      check("mid_rst_busy", 64'(busy), 64'(0));
      check("mid_rst_resp_valid", 64'(resp_valid), 64'(0));
      check("mid_rst_alu_a", 64'(alu_a), 64'(0));
      check("mid_rst_alu_op", 64'(alu_op), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("post_rst_no_resp", 64'(resp_valid), 64'(0));
         check("post_rst_busy", 64'(busy), 64'(0));
      end
      do_txn(2'b01, ALU_OP_AND, 32'hFF, 32'h0F, '0, '0, '0, 0, g_tmp, d_tmp);
      check("post_rst_data", 64'(d_tmp), 64'h0F);

      // Randomized traffic against the model
      for (int i = 0; i < 40; i++) begin
         logic [1:0] v;
         v = 2'($urandom_range(1, 3));
         do_txn(v, 6'($urandom_range(0, 11)), $urandom, $urandom,
                6'($urandom_range(0, 11)), $urandom, $urandom,
                $urandom_range(0, 3), g_tmp, d_tmp);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
